hazard_ctrl: RTL and testbench

- Pipeline hazard controller. It is the producer side of the ID/EX `stop` interface.
- Detects load-use and RAW data hazards between the ID instruction and the instructions in EX/MEM/WB.
- Detects control hazards from the EX-stage branch/jump resolution.
- Drives the stall, bubble and flush controls for the PC, IF/ID and ID/EX registers, plus registered forwarding selects consumed by EX.

---
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush for PC, IF/ID, ID/EX plus registered EX forward selects.
// Build option HAZARD_FWD_EN: forwarding enabled, only load-use stalls (one bubble).
module hazard_ctrl #(
   parameter logic [1:0] LOAD_SEL = 2'b01,
   parameter int         CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic             re1_id,
   input  logic             re2_id,
   input  logic [4:0]       wR_ex,
   input  logic             rf_we_ex,
   input  logic [1:0]       wd_sel_ex,
   input  logic [4:0]       wR_mem,
   input  logic             rf_we_mem,
   input  logic [4:0]       wR_wb,
   input  logic             rf_we_wb,
   input  logic             br_taken_ex,
   output logic             keep_pc,
   output logic             keep_ifid,
   output logic             flush_ifid,
   output logic             stop,
   output logic [1:0]       fwd_a_ex,
   output logic [1:0]       fwd_b_ex,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // state    | meaning
   // ST_RUN   | normal issue, hazards and redirects evaluated
   // ST_STALL | holding PC and IF/ID, cnt more bubble cycles to go
   // ST_FLUSH | cooldown after a redirect, br_taken_ex ignored
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0] state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic [1:0] hz_len;
   logic       keep_raw, flush_raw, stop_raw;

   logic m1_ex, m2_ex, m1_mem, m2_mem;

   assign m1_ex  = re1_id & rf_we_ex  & (wR_ex  == rs1_id) & (rs1_id != 5'd0);
   assign m2_ex  = re2_id & rf_we_ex  & (wR_ex  == rs2_id) & (rs2_id != 5'd0);
   assign m1_mem = re1_id & rf_we_mem & (wR_mem == rs1_id) & (rs1_id != 5'd0);
   assign m2_mem = re2_id & rf_we_mem & (wR_mem == rs2_id) & (rs2_id != 5'd0);

`ifdef HAZARD_FWD_EN
   logic load_use;
   logic unused_wb;

   assign load_use  = rf_we_ex & (wd_sel_ex == LOAD_SEL) & (m1_ex | m2_ex);
   assign hz_len    = load_use ? 2'd1 : 2'd0;
   assign unused_wb = ^{wR_wb, rf_we_wb};
`else
   logic       m1_wb, m2_wb;
   logic [1:0] len_a, len_b;
   logic       unused_sel;

   assign m1_wb  = re1_id & rf_we_wb & (wR_wb == rs1_id) & (rs1_id != 5'd0);
   assign m2_wb  = re2_id & rf_we_wb & (wR_wb == rs2_id) & (rs2_id != 5'd0);
   // Without forwarding the consumer waits until the producer has retired.
   assign len_a  = m1_ex ? 2'd3 : m1_mem ? 2'd2 : m1_wb ? 2'd1 : 2'd0;
   assign len_b  = m2_ex ? 2'd3 : m2_mem ? 2'd2 : m2_wb ? 2'd1 : 2'd0;
   assign hz_len = (len_a > len_b) ? len_a : len_b;
   assign unused_sel = (wd_sel_ex == LOAD_SEL);
`endif

   // The detecting RUN cycle is the first bubble, so STALL covers the remaining hz_len-1.
   always_comb begin
      keep_raw  = 1'b0;
      flush_raw = 1'b0;
      stop_raw  = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_STALL: begin
            if (br_taken_ex) begin
               flush_raw = 1'b1;
               stop_raw  = 1'b1;
               cnt_nxt   = 2'd0;
               state_nxt = ST_FLUSH;
            end else begin
               keep_raw  = 1'b1;
               stop_raw  = 1'b1;
               cnt_nxt   = cnt - 2'd1;
               if (cnt <= 2'd1) state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            if (br_taken_ex && (state != ST_FLUSH)) begin
               flush_raw = 1'b1;
               stop_raw  = 1'b1;
               cnt_nxt   = 2'd0;
               state_nxt = ST_FLUSH;
            end else if (hz_len != 2'd0) begin
               keep_raw  = 1'b1;
               stop_raw  = 1'b1;
               cnt_nxt   = hz_len - 2'd1;
               if (hz_len > 2'd1) state_nxt = ST_STALL;
            end
         end
      endcase
   end

   assign keep_pc    = keep_raw  & rst_n;
   assign keep_ifid  = keep_raw  & rst_n;
   assign flush_ifid = flush_raw & rst_n;
   assign stop       = stop_raw  & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef HAZARD_FWD_EN
   // ID-vs-EX becomes MEM forwarding next cycle, ID-vs-MEM becomes WB forwarding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_ex <= 2'b00;
         fwd_b_ex <= 2'b00;
      end else if (stop_raw || flush_raw) begin
         fwd_a_ex <= 2'b00;
         fwd_b_ex <= 2'b00;
      end else begin
         fwd_a_ex <= m1_ex ? 2'b01 : m1_mem ? 2'b10 : 2'b00;
         fwd_b_ex <= m2_ex ? 2'b01 : m2_mem ? 2'b10 : 2'b00;
      end
   end
`else
   assign fwd_a_ex = 2'b00;
   assign fwd_b_ex = 2'b00;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (keep_raw)  stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (flush_raw) flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic against a cycle-count model.
module tb_hazard_ctrl;

   logic        clk, rst_n;
   logic [4:0]  rs1_id, rs2_id, wR_ex, wR_mem, wR_wb;
   logic        re1_id, re2_id, rf_we_ex, rf_we_mem, rf_we_wb, br_taken_ex;
   logic [1:0]  wd_sel_ex;
   logic        keep_pc, keep_ifid, flush_ifid, stop;
   logic [1:0]  fwd_a_ex, fwd_b_ex;
   logic [31:0] stall_cnt, flush_cnt;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .re1_id(re1_id), .re2_id(re2_id),
      .wR_ex(wR_ex), .rf_we_ex(rf_we_ex), .wd_sel_ex(wd_sel_ex),
      .wR_mem(wR_mem), .rf_we_mem(rf_we_mem),
      .wR_wb(wR_wb), .rf_we_wb(rf_we_wb),
      .br_taken_ex(br_taken_ex),
      .keep_pc(keep_pc), .keep_ifid(keep_ifid), .flush_ifid(flush_ifid), .stop(stop),
      .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs1; logic [4:0] rs2; logic re1; logic re2;
      logic [4:0] wr_ex; logic we_ex; logic [1:0] wd_ex;
      logic [4:0] wr_mem; logic we_mem;
      logic [4:0] wr_wb; logic we_wb;
      logic br;
   } stim_t;

   typedef struct {
      logic keep, flush, stop;
      logic [1:0] fa, fb;
      logic [31:0] sc, fc;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_err = 0;

   // Reference model: bubbles still owed, cooldown flag, registered values.
   int          m_left;
   bit          m_cool;
   logic [1:0]  m_fa, m_fb;
   logic [31:0] m_sc, m_fc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int src_len(input logic re, input logic [4:0] rs, input stim_t s);
      if (!re || rs == 5'd0) return 0;
      if (s.we_ex  && s.wr_ex  == rs) return 3;
      if (s.we_mem && s.wr_mem == rs) return 2;
      if (s.we_wb  && s.wr_wb  == rs) return 1;
      return 0;
   endfunction

   function automatic logic [1:0] fsel(input logic re, input logic [4:0] rs, input stim_t s);
      if (!re || rs == 5'd0) return 2'b00;
      if (s.we_ex  && s.wr_ex  == rs) return 2'b01;
      if (s.we_mem && s.wr_mem == rs) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_left = 0; m_cool = 0; m_fa = 2'b00; m_fb = 2'b00; m_sc = 0; m_fc = 0;
   endtask

   task automatic apply(input stim_t s);
      rs1_id = s.rs1; rs2_id = s.rs2; re1_id = s.re1; re2_id = s.re2;
      wR_ex = s.wr_ex; rf_we_ex = s.we_ex; wd_sel_ex = s.wd_ex;
      wR_mem = s.wr_mem; rf_we_mem = s.we_mem;
      wR_wb = s.wr_wb; rf_we_wb = s.we_wb;
      br_taken_ex = s.br;
   endtask

   task automatic drive(input stim_t s);
      exp_t e;
      int   l1, l2, need;
      bit   cool_n;
      @(posedge clk); #1;
      apply(s);
      e.fa = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc;
      e.keep = 0; e.flush = 0; e.stop = 0;
      l1 = src_len(s.re1, s.rs1, s);
      l2 = src_len(s.re2, s.rs2, s);
`ifdef HAZARD_FWD_EN
      need = (s.wd_ex == 2'b01 && (l1 == 3 || l2 == 3)) ? 1 : 0;
`else
      need = (l1 > l2) ? l1 : l2;
`endif
      cool_n = 0;
      if (m_left > 0) begin
         if (s.br) begin
            e.flush = 1; e.stop = 1; m_left = 0; cool_n = 1;
         end else begin
            e.keep = 1; e.stop = 1; m_left--;
         end
      end else if (s.br && !m_cool) begin
         e.flush = 1; e.stop = 1; cool_n = 1;
      end else if (need > 0) begin
         e.keep = 1; e.stop = 1; m_left = need - 1;
      end
      m_cool = cool_n;
      q.push_back(e);
      if (e.stop || e.flush) begin
         m_fa = 2'b00; m_fb = 2'b00;
      end else begin
`ifdef HAZARD_FWD_EN
         m_fa = fsel(s.re1, s.rs1, s);
         m_fb = fsel(s.re2, s.rs2, s);
`else
         m_fa = 2'b00; m_fb = 2'b00;
`endif
      end
      if (e.keep)  m_sc = m_sc + 1;
      if (e.flush) m_fc = m_fc + 1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      stim_t z = '0;
      @(negedge clk); #1;
      rst_n = 1'b0;
      apply(z);
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("ctrl", {28'd0, keep_pc, keep_ifid, flush_ifid, stop},
                        {28'd0, e.keep, e.keep, e.flush, e.stop});
            chk("fwd", {28'd0, fwd_a_ex, fwd_b_ex}, {28'd0, e.fa, e.fb});
            chk("stall_cnt", stall_cnt, e.sc);
            chk("flush_cnt", flush_cnt, e.fc);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      stim_t s;
      rst_n = 1'b0;
      s = '0;
      apply(s);
      model_reset();
      #12;
      chk("reset_ctrl", {28'd0, keep_pc, keep_ifid, flush_ifid, stop}, 32'd0);
      chk("reset_cnt", stall_cnt | flush_cnt, 32'd0);
      rst_n = 1'b1;

`ifdef HAZARD_FWD_EN
      // load x5 in EX, ID reads x5: one bubble, then WB forward
      do_reset();
      s = '0; s.rs1 = 5; s.re1 = 1; s.wr_ex = 5; s.we_ex = 1; s.wd_ex = 2'b01; drive(s);
      s = '0; s.rs1 = 5; s.re1 = 1; s.wr_mem = 5; s.we_mem = 1; drive(s);
      s = '0; drive(s);
      settle();
      chk("lu_fwd_a", {30'd0, fwd_a_ex}, 32'd2);
      chk("lu_stall_cnt", stall_cnt, 32'd1);
      // ALU x7 in EX, ID reads rs2=x7: no stall, MEM forward
      do_reset();
      s = '0; s.rs2 = 7; s.re2 = 1; s.wr_ex = 7; s.we_ex = 1; drive(s);
      s = '0; drive(s);
      settle();
      chk("alu_fwd_b", {30'd0, fwd_b_ex}, 32'd1);
      chk("alu_stall_cnt", stall_cnt, 32'd0);
      // x0 never forwards
      do_reset();
      s = '0; s.re1 = 1; s.re2 = 1; s.we_ex = 1; drive(s);
      s = '0; drive(s);
      settle();
      chk("x0_fwd", {28'd0, fwd_a_ex, fwd_b_ex}, 32'd0);
`else
      // EX writes x3, ID reads x3: three bubbles as the producer drains
      do_reset();
      s = '0; s.rs1 = 3; s.re1 = 1; s.wr_ex = 3; s.we_ex = 1; drive(s);
      s = '0; s.rs1 = 3; s.re1 = 1; s.wr_mem = 3; s.we_mem = 1; drive(s);
      s = '0; s.rs1 = 3; s.re1 = 1; s.wr_wb = 3; s.we_wb = 1; drive(s);
      s = '0; s.rs1 = 3; s.re1 = 1; drive(s);
      settle();
      chk("ex3_keep_after", {31'd0, keep_pc}, 32'd0);
      chk("ex3_stall_cnt", stall_cnt, 32'd3);
      // MEM match only: two bubbles
      do_reset();
      s = '0; s.rs2 = 4; s.re2 = 1; s.wr_mem = 4; s.we_mem = 1; drive(s);
      s = '0; s.rs2 = 4; s.re2 = 1; s.wr_wb = 4; s.we_wb = 1; drive(s);
      s = '0; drive(s);
      settle();
      chk("mem2_stall_cnt", stall_cnt, 32'd2);
      // redirect on 2nd cycle of a 3-cycle stall
      do_reset();
      s = '0; s.rs1 = 3; s.re1 = 1; s.wr_ex = 3; s.we_ex = 1; drive(s);
      s = '0; s.rs1 = 3; s.re1 = 1; s.wr_mem = 3; s.we_mem = 1; s.br = 1; drive(s);
      s = '0; drive(s);
      settle();
      chk("abort_stall_cnt", stall_cnt, 32'd1);
      chk("abort_flush_cnt", flush_cnt, 32'd1);
`endif
      // redirect together with load-use: branch wins
      do_reset();
      s = '0; s.rs1 = 9; s.re1 = 1; s.wr_ex = 9; s.we_ex = 1; s.wd_ex = 2'b01; s.br = 1; drive(s);
      s = '0; s.br = 1; drive(s);
      s = '0; drive(s);
      settle();
      chk("br_lu_flush_cnt", flush_cnt, 32'd1);
      chk("br_lu_stall_cnt", stall_cnt, 32'd0);

      // reset asserted mid-stall with a hazard and redirect still present
      do_reset();
      s = '0; s.rs1 = 6; s.re1 = 1; s.wr_ex = 6; s.we_ex = 1; s.wd_ex = 2'b01; drive(s);
      s.br = 0; drive(s);
      settle();
      s.br = 1; apply(s);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ctrl", {28'd0, keep_pc, keep_ifid, flush_ifid, stop}, 32'd0);
      chk("rst_mid_cnt", stall_cnt | flush_cnt, 32'd0);
      chk("rst_mid_fwd", {28'd0, fwd_a_ex, fwd_b_ex}, 32'd0);
      s = '0; apply(s);
      #2;
      rst_n = 1'b1;
      model_reset();
      s = '0; drive(s);
      drive(s);

      for (int i = 0; i < 2000; i++) begin
         s.rs1    = 5'($urandom_range(0, 7));
         s.rs2    = 5'($urandom_range(0, 7));
         s.re1    = 1'($urandom_range(0, 1));
         s.re2    = 1'($urandom_range(0, 1));
         s.wr_ex  = 5'($urandom_range(0, 7));
         s.we_ex  = 1'($urandom_range(0, 1));
         s.wd_ex  = 2'($urandom_range(0, 3));
         s.wr_mem = 5'($urandom_range(0, 7));
         s.we_mem = 1'($urandom_range(0, 1));
         s.wr_wb  = 5'($urandom_range(0, 7));
         s.we_wb  = 1'($urandom_range(0, 1));
         s.br     = ($urandom_range(0, 7) == 0);
         drive(s);
      end
      s = '0; drive(s);
      settle();
      chk("queue_drained", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
